data_sram_resp: RTL
===================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, word-address width of the internal array (2^DEPTH_LOG2 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 1, extra read wait states inserted before the read response (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 data_sram_en  input  1  request valid from EX stage.
REQ-006 data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 denotes a read.
REQ-007 data_sram_addr  input  32  byte address.
REQ-008 data_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
REQ-009 data_sram_rdata  output  32  read data, registered.
REQ-010 rdata_valid  output  1  one-cycle pulse marking data_sram_rdata as the new read result.
REQ-011 stallreq  output  1  stall request to the pipeline stall controller while a read is outstanding.
REQ-012 addr_err  output  1  registered out-of-range flag (present only with DSRAM_ADDR_CHECK_EN).

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP; the reset state is IDLE.
REQ-014 Word index SHALL be data_sram_addr[DEPTH_LOG2+1:2]; addr[1:0] ignored; higher bits alias unless REQ-027 applies.
REQ-015 A write (en=1, wen!=0) in IDLE SHALL update only the enabled byte lanes at the same edge, with no stall and no state change.
REQ-016 A read (en=1, wen=0) in IDLE SHALL latch the word index and go to WAIT if WAIT_CYCLES>0, else directly to RESP.
REQ-017 In WAIT a counter SHALL count from 1 to WAIT_CYCLES; on reaching WAIT_CYCLES the FSM goes to RESP.
REQ-018 On entering RESP, data_sram_rdata SHALL load the array word at the latched index and rdata_valid SHALL be 1 for exactly that cycle; RESP returns to IDLE unconditionally.
REQ-019 Read latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to rdata_valid.
REQ-020 stallreq SHALL be combinationally 1 when (state==IDLE and read request present) or state==WAIT, and 0 in RESP.
REQ-021 data_sram_rdata SHALL hold its value until the next RESP.
REQ-022 Requests arriving in WAIT or RESP SHALL be ignored; the initiator re-presents them because it is stalled.
REQ-023 A read of a word written in an earlier cycle SHALL return the written data, since the array is updated before the read is sampled.
REQ-024 Array contents SHALL NOT be reset.

Reset
REQ-025 On resetn=0 (asynchronous): state=IDLE, wait counter=0, data_sram_rdata=0, rdata_valid=0, addr_err=0, and stallreq forced to 0.
REQ-026 Reset asserted during WAIT or RESP SHALL abort the read with no rdata_valid pulse; array contents are retained.

Configuration
REQ-027 With macro DSRAM_ADDR_CHECK_EN defined:
- any request with data_sram_addr[31:DEPTH_LOG2+2] != 0 is out of range;
- out-of-range writes are suppressed;
- out-of-range reads run the normal FSM and return 32'h0;
- addr_err is set for one cycle at the edge that accepts the request.
REQ-028 Without DSRAM_ADDR_CHECK_EN, addr_err SHALL be absent, and upper address bits alias per REQ-014.

Verification
REQ-029 Reset, then write wen=4'b1111 addr=0x10 wdata=0xDEADBEEF, then read 0x10 with WAIT_CYCLES=1 -> stallreq high 2 cycles; rdata_valid pulses 2 cycles after accept with rdata=0xDEADBEEF.
REQ-030 Write 0x11223344 to 0x20, then wen=4'b0010 wdata=0x0000AA00 -> read 0x20 returns 0x1122AA44.
REQ-031 WAIT_CYCLES=0, back-to-back reads of 0x10 and 0x20 -> each returns in 1 cycle, stallreq high only in the IDLE accept cycle, second request accepted the cycle after RESP.
REQ-032 resetn low for 1 cycle while in WAIT -> no rdata_valid, state IDLE, rdata=0; a subsequent read of 0x10 still returns 0xDEADBEEF.
REQ-033 DSRAM_ADDR_CHECK_EN, DEPTH_LOG2=10, write 0x55 to 0x1000 -> addr_err pulses and the write is suppressed; read 0x1000 returns 0x0 with addr_err pulse; read 0x0 is unchanged.
REQ-034 Write request arriving in WAIT -> ignored; array unchanged at that address.

Source files
------------

// File: rtl/data_sram_resp.sv
`timescale 1ns/1ps
// data_sram_resp: single-port 32-bit data SRAM with a stalled, fixed-latency
// read response. Writes complete in the IDLE cycle that presents them; reads
// stall the pipeline for WAIT_CYCLES wait states and then return registered
// data with a one-cycle rdata_valid pulse.
//
// Optional build macro DSRAM_ADDR_CHECK_EN: adds the addr_err output. With it,
// requests whose address bits above the array range are non-zero are flagged:
// their writes are dropped and their reads return zero.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting requests; writes land here, reads are latched
// WAIT  | read outstanding, counting wait states 1..WAIT_CYCLES
// RESP  | rdata_valid high with the new read word; requests ignored

module data_sram_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        stallreq
`ifdef DSRAM_ADDR_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_TC = 4'(WAIT_CYCLES);

    logic [31:0]           mem [DEPTH];

    state_t                state_q;
    state_t                state_d;
    logic [3:0]            wait_cnt_q;
    logic [3:0]            wait_cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  oob_q;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] resp_idx;
    logic                  resp_oob;
    logic                  addr_oob;
    logic                  rd_req;
    logic                  wr_req;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  load_resp;
    logic                  unused_addr_bits;

    assign req_idx = data_sram_addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_ADDR_CHECK_EN
    assign addr_oob         = |data_sram_addr[31:DEPTH_LOG2+2];
    assign unused_addr_bits = ^data_sram_addr[1:0];
`else
    // Upper address bits alias onto the array when range checking is off.
    assign addr_oob         = 1'b0;
    assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:DEPTH_LOG2+2]};
`endif

    assign rd_req    = data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_req    = data_sram_en && (data_sram_wen != 4'b0000);
    assign accept_rd = (state_q == IDLE) && rd_req;
    assign accept_wr = (state_q == IDLE) && wr_req && !addr_oob;

    // With zero wait states the response loads at the accepting edge, before
    // the index register has captured the request, so bypass it.
    assign resp_idx = (state_q == IDLE) ? req_idx  : idx_q;
    assign resp_oob = (state_q == IDLE) ? addr_oob : oob_q;

    // Reset gates the stall so the pipeline is never held while in reset.
    assign stallreq = resetn && (accept_rd || (state_q == WAIT));

    // Next-state and wait-state counting.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        load_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_TC) begin
                    state_d    = RESP;
                    wait_cnt_d = 4'd0;
                    load_resp  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // State, counter, latched request and registered read response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            wait_cnt_q      <= 4'd0;
            idx_q           <= '0;
            oob_q           <= 1'b0;
            data_sram_rdata <= 32'h0;
            rdata_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_valid <= load_resp;
            if (accept_rd) begin
                idx_q <= req_idx;
                oob_q <= addr_oob;
            end
            if (load_resp) begin
                data_sram_rdata <= resp_oob ? 32'h0 : mem[resp_idx];
            end
        end
    end

`ifdef DSRAM_ADDR_CHECK_EN
    // Out-of-range flag pulses for the cycle after the accepting edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (state_q == IDLE) && data_sram_en && addr_oob;
        end
    end
`endif

    // Byte-lane writes; the array itself keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem[req_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
